// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the unified instruction/data memory.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'b00,
    ST_IDLE  = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_t;

  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << lane;
      SZ_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lane_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic sign_ext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = {{24{sign_ext & b[7]}}, b};
      SZ_HALF: r = {{16{sign_ext & h[15]}}, h};
      SZ_WORD: r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Combinational lane steering: merges store data into the stored word and
// extracts/extends the addressed lane for loads.
module mem_lane_unit
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] stored,
  output logic [31:0] merged,
  output logic [31:0] rd_ext
);

  logic [3:0]  mask_s;
  logic [31:0] repl_s;

  // Replicate store data across lanes, then keep only the addressed bytes
  always_comb begin
    mask_s = byte_mask(size, lane);
    case (size)
      SZ_BYTE: repl_s = {4{wdata[7:0]}};
      SZ_HALF: repl_s = {2{wdata[15:0]}};
      default: repl_s = wdata;
    endcase
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = mask_s[i] ? repl_s[8*i +: 8] : stored[8*i +: 8];
    end
    rd_ext = lane_extend(stored, size, lane, sign_ext);
  end

endmodule

// File: rtl/mem_unified_hs.sv
// Unified instruction/data memory with req/ready handshake, fixed access
// latency, sub-word accesses, error reporting, post-reset data clear and program load.
module mem_unified_hs
  import mem_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int INST_WORDS   = 32,
  parameter int LATENCY      = 2,
  parameter int INST_PROTECT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 we,
  input  logic [1:0]           size,
  input  logic                 sign_ext,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic                 ready,
  output logic                 err,
  output logic                 busy,
  input  logic                 prog_we,
  input  logic [ADDR_BITS-1:0] prog_addr,
  input  logic [31:0]          prog_data
);

  localparam int                   DEPTH      = 2**ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_IDX   = ADDR_BITS'(DEPTH-1);
  localparam logic [ADDR_BITS-1:0] FIRST_DATA = ADDR_BITS'(INST_WORDS);
  localparam logic [3:0]           LAT_LOAD   = 4'(LATENCY-1);
  localparam bit                   PROTECT_EN = INST_PROTECT[0];

  logic [31:0] mem_r [DEPTH];

  state_t                state_r, state_s;
  logic [3:0]            lat_cnt_r, lat_cnt_s;
  logic [ADDR_BITS-1:0]  clr_cnt_r;
  logic                  we_r, sign_ext_r, acc_err_r;
  logic [1:0]            size_r, lane_r;
  logic [ADDR_BITS-1:0]  idx_r;
  logic [31:0]           wdata_r;
  logic                  ready_r, err_r, busy_r;
  logic [31:0]           rdata_r;

  logic                  accept_s, clear_en_s, commit_s, req_err_s;
  logic                  cur_we_s, cur_sx_s, cur_err_s;
  logic [1:0]            cur_size_s, cur_lane_s;
  logic [ADDR_BITS-1:0]  cur_idx_s;
  logic [31:0]           cur_wdata_s, merged_s, rd_ext_s;

  assign req_err_s = (size == 2'b11)
                   | ((size == SZ_HALF) & addr[0])
                   | ((size == SZ_WORD) & (addr[1:0] != 2'b00))
                   | (addr[31:ADDR_BITS+2] != '0)
                   | (PROTECT_EN & we & (32'(addr[ADDR_BITS+1:2]) < 32'(INST_WORDS)));

  // With LATENCY=1 the response is built in the acceptance cycle, so use the live port fields
  always_comb begin
    if (accept_s) begin
      cur_we_s    = we;
      cur_sx_s    = sign_ext;
      cur_err_s   = req_err_s;
      cur_size_s  = size;
      cur_lane_s  = addr[1:0];
      cur_idx_s   = addr[ADDR_BITS+1:2];
      cur_wdata_s = wdata;
    end else begin
      cur_we_s    = we_r;
      cur_sx_s    = sign_ext_r;
      cur_err_s   = acc_err_r;
      cur_size_s  = size_r;
      cur_lane_s  = lane_r;
      cur_idx_s   = idx_r;
      cur_wdata_s = wdata_r;
    end
  end

  mem_lane_unit u_lane (
    .size     (cur_size_s),
    .lane     (cur_lane_s),
    .sign_ext (cur_sx_s),
    .wdata    (cur_wdata_s),
    .stored   (mem_r[cur_idx_s]),
    .merged   (merged_s),
    .rd_ext   (rd_ext_s)
  );

  // Next-state logic, latency countdown and array write enables
  always_comb begin
    state_s    = state_r;
    lat_cnt_s  = lat_cnt_r;
    accept_s   = 1'b0;
    clear_en_s = 1'b0;
    commit_s   = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        clear_en_s = 1'b1;
        if (clr_cnt_r == LAST_IDX) state_s = ST_IDLE;
        else                       state_s = ST_CLEAR;
      end
      ST_IDLE: begin
        if (req) begin
          accept_s  = 1'b1;
          lat_cnt_s = LAT_LOAD;
          state_s   = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (lat_cnt_r == 4'd1) begin
          lat_cnt_s = 4'd0;
          state_s   = ST_RESP;
        end else begin
          lat_cnt_s = lat_cnt_r - 4'd1;
          state_s   = ST_WAIT;
        end
      end
      ST_RESP: begin
        commit_s = we_r & ~acc_err_r;
        state_s  = ST_IDLE;
      end
      default: state_s = ST_CLEAR;
    endcase
  end

  // Control state, request latch and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_CLEAR;
      lat_cnt_r  <= 4'd0;
      clr_cnt_r  <= FIRST_DATA;
      we_r       <= 1'b0;
      sign_ext_r <= 1'b0;
      acc_err_r  <= 1'b0;
      size_r     <= 2'b00;
      lane_r     <= 2'b00;
      idx_r      <= '0;
      wdata_r    <= 32'h0000_0000;
      ready_r    <= 1'b0;
      err_r      <= 1'b0;
      rdata_r    <= 32'h0000_0000;
      busy_r     <= 1'b1;
    end else begin
      state_r   <= state_s;
      lat_cnt_r <= lat_cnt_s;
      if (clear_en_s) clr_cnt_r <= clr_cnt_r + ADDR_BITS'(1'b1);
      if (accept_s) begin
        we_r       <= we;
        sign_ext_r <= sign_ext;
        acc_err_r  <= req_err_s;
        size_r     <= size;
        lane_r     <= addr[1:0];
        idx_r      <= addr[ADDR_BITS+1:2];
        wdata_r    <= wdata;
      end
      ready_r <= (state_s == ST_RESP);
      err_r   <= (state_s == ST_RESP) & cur_err_s;
      rdata_r <= ((state_s == ST_RESP) && !cur_err_s && !cur_we_s) ? rd_ext_s : 32'h0000_0000;
      busy_r  <= (state_s == ST_CLEAR);
    end
  end

  // Storage writes; the program port is applied last so it wins any same-word collision
  always_ff @(posedge clk) begin
    if (commit_s)   mem_r[idx_r]     <= merged_s;
    if (clear_en_s) mem_r[clr_cnt_r] <= 32'h0000_0000;
    if (prog_we)    mem_r[prog_addr] <= prog_data;
  end

  assign rdata = rdata_r;
  assign ready = ready_r;
  assign err   = err_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_mem_unified_hs.sv
// Scoreboard bench for mem_unified_hs: byte-array reference model, random and
// directed accesses, plus a LATENCY=1 instance for back-to-back and collision cases.
module tb_mem_unified_hs;

  localparam int ADDR_BITS  = 8;
  localparam int DEPTH      = 256;
  localparam int INST_WORDS = 32;
  localparam int LAT        = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic                 req, we, sign_ext, ready, err, busy, prog_we;
  logic [1:0]           size;
  logic [31:0]          addr, wdata, rdata, prog_data;
  logic [ADDR_BITS-1:0] prog_addr;

  logic                 req1, we1, sx1, ready1, err1, busy1, prog_we1;
  logic [1:0]           size1;
  logic [31:0]          addr1, wdata1, rdata1, prog_data1;
  logic [ADDR_BITS-1:0] prog_addr1;

  mem_unified_hs #(.ADDR_BITS(ADDR_BITS), .INST_WORDS(INST_WORDS), .LATENCY(LAT), .INST_PROTECT(1)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err), .busy(busy),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data));

  mem_unified_hs #(.ADDR_BITS(ADDR_BITS), .INST_WORDS(INST_WORDS), .LATENCY(1), .INST_PROTECT(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .we(we1), .size(size1), .sign_ext(sx1),
    .addr(addr1), .wdata(wdata1), .rdata(rdata1), .ready(ready1), .err(err1), .busy(busy1),
    .prog_we(prog_we1), .prog_addr(prog_addr1), .prog_data(prog_data1));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk_data;
    int          issue;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mb [DEPTH*4];
  int         n_checks = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         ready_seen = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: memory as a little-endian byte array
  function automatic logic model_err(input logic w, input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) ||
           (a >= 32'(DEPTH*4)) || (w && a < 32'(INST_WORDS*4));
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sx, input logic [31:0] a);
    int n;
    logic [31:0] v;
    n = 1 << sz;
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(mb[a+32'(i)]) << (8*i));
    if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < (1 << sz); i++) mb[a+32'(i)] = 8'(wd >> (8*i));
  endtask

  task automatic set_word(input int idx, input logic [31:0] v);
    for (int i = 0; i < 4; i++) mb[idx*4+i] = 8'(v >> (8*i));
  endtask

  task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int   n;
    @(negedge clk);
    e.err      = model_err(w, sz, a);
    e.rdata    = (e.err || w) ? 32'h0 : model_load(sz, sx, a);
    e.chk_data = e.err || !w;
    e.issue    = cyc;
    sb.push_back(e);
    if (!e.err && w) model_store(sz, a, wd);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ready !== 1'b1 && n < 40);
    if (ready !== 1'b1) begin
      n_checks++;
      n_err++;
      $display("FAIL access_timeout: no ready within %0d cycles, addr=%h", n, a);
      void'(sb.pop_front());
    end
    req = 1'b0;
  endtask

  task automatic access1(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic ok);
    int n;
    @(negedge clk);
    req1 = 1'b1; we1 = w; size1 = 2'b10; sx1 = 1'b0; addr1 = a; wdata1 = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ready1 !== 1'b1 && n < 20);
    ok = (ready1 === 1'b1);
    rd = rdata1;
    req1 = 1'b0;
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ready === 1'b1) begin
        ready_seen++;
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_ready: ready=1 with nothing outstanding (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("resp_err", 32'(err), 32'(e.err));
          if (e.chk_data) check("resp_rdata", rdata, e.rdata);
          check("latency", 32'(cyc - e.issue), 32'(LAT));
        end
      end
    end
  end

  initial begin
    int          n, rs, rc, first;
    logic        prev, adj, ok;
    logic [31:0] rd;

    reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = 32'h0; wdata = 32'h0; prog_we = 1'b0; prog_addr = '0; prog_data = 32'h0;
    req1 = 1'b0; we1 = 1'b0; size1 = 2'b00; sx1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;
    prog_we1 = 1'b0; prog_addr1 = '0; prog_data1 = 32'h0;
    for (int b = 0; b < DEPTH*4; b++) mb[b] = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_busy", 32'(busy), 32'h1);

    // Program all instruction words during CLEAR; the last write collides with the clear of word 64
    reset = 1'b0;
    for (int j = 0; j < 33; j++) begin
      prog_we   = 1'b1;
      prog_addr = (j < 32) ? 8'(j) : 8'd64;
      prog_data = (j == 3) ? 32'h1000_FFFF : (j == 32) ? 32'hCAFE_F00D : $urandom;
      set_word(int'(prog_addr), prog_data);
      @(negedge clk);
    end
    prog_we = 1'b0;
    n = 33;
    while (busy === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("clear_cycles", 32'(n), 32'd224);

    access(1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
    access(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
    access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    access(1'b1, 2'b10, 1'b0, 32'h80, 32'h1122_3344);
    access(1'b1, 2'b00, 1'b0, 32'h83, 32'h0000_00AB);
    access(1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
    access(1'b0, 2'b00, 1'b1, 32'h83, 32'h0);
    access(1'b0, 2'b01, 1'b0, 32'h82, 32'h0);
    access(1'b1, 2'b01, 1'b0, 32'h81, 32'h0000_FFFF);
    access(1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
    access(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    access(1'b1, 2'b10, 1'b0, 32'h0C, 32'h0000_DEAD);
    access(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
    access(1'b0, 2'b11, 1'b0, 32'h84, 32'h0);

    // Reset while a store sits in WAIT: it must vanish without a ready pulse
    @(negedge clk);
    rs = ready_seen;
    req = 1'b1; we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h90; wdata = 32'h5A5A_5A5A;
    @(posedge clk);
    #1 reset = 1'b1;
    req = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'h1);
    check("abort_ready", 32'(ready), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int b = INST_WORDS*4; b < DEPTH*4; b++) mb[b] = 8'h00;
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("reclear_done", 32'(busy), 32'h0);
    check("abort_no_ready", 32'(ready_seen), 32'(rs));
    access(1'b0, 2'b10, 1'b0, 32'h90, 32'h0);
    access(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);

    for (int k = 0; k < 150; k++) begin
      logic        w;
      logic [1:0]  sz;
      logic [31:0] a;
      int          r;
      w  = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 7);
      sz = (r == 7) ? 2'b11 : 2'(r % 3);
      a  = 32'($urandom_range(0, DEPTH*4-1));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        else if (sz == 2'b10) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 15) == 0) a[$urandom_range(10, 31)] = 1'b1;
      access(w, sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    // LATENCY=1 instance: held req gives a ready every second cycle
    n = 0;
    while (busy1 === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b0; size1 = 2'b10; sx1 = 1'b0; addr1 = 32'h80;
    rc = 0; first = -1; prev = 1'b0; adj = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ready1 === 1'b1) begin
        rc++;
        if (prev) adj = 1'b1;
        if (first < 0) begin
          first = k;
          check("l1_b2b_rdata", rdata1, 32'h0);
        end
      end
      prev = (ready1 === 1'b1);
    end
    req1 = 1'b0;
    check("l1_b2b_count", 32'(rc), 32'd4);
    check("l1_b2b_gap", 32'(adj), 32'h0);
    check("l1_first_latency", 32'(first), 32'd1);

    access1(1'b1, 32'h88, 32'h0BAD_CAFE, rd, ok);
    check("l1_store_ok", 32'(ok), 32'h1);
    access1(1'b0, 32'h88, 32'h0, rd, ok);
    check("l1_store_rdata", rd, 32'h0BAD_CAFE);

    // Store commit and program write hit word 0x21 on the same edge
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; size1 = 2'b10; addr1 = 32'h84; wdata1 = 32'h1234_5678;
    @(negedge clk);
    check("l1_collide_ready", 32'(ready1), 32'h1);
    prog_we1 = 1'b1; prog_addr1 = 8'h21; prog_data1 = 32'hDEAD_BEEF;
    req1 = 1'b0;
    @(negedge clk);
    prog_we1 = 1'b0;
    access1(1'b0, 32'h84, 32'h0, rd, ok);
    check("l1_prog_wins", rd, 32'hDEAD_BEEF);

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
